// File: rtl/main_fsm.sv
// Multicycle control FSM for the ARM-subset core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and raw strobes.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Kept as a plain vector so codes 10-15 are representable and recoverable.
  logic [3:0] state_q;
  state_t     state_d;
  logic       held;
  logic       strobe_en;

  logic       irwrite_raw;
  logic       nextpc_raw;
  logic       regw_raw;
  logic       memw_raw;
  logic       branch_raw;

  // cmd bits are decoded by decode_alu, not here.
  logic       unused_cmd;
  assign unused_cmd = ^Funct[4:1];

  // held spends the first edge after reset release in FETCH, so the FETCH
  // strobes are issued for exactly one full cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      held    <= 1'b1;
    end else if (held) begin
      held    <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    irwrite_raw = 1'b0;
    nextpc_raw  = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ALUOp       = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    branch_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        irwrite_raw = 1'b1;
        nextpc_raw  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUOp = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        regw_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch_raw = 1'b1;
      end
      default: begin
        irwrite_raw = 1'b0;
      end
    endcase
  end

  // Strobes are suppressed during reset and during the post-release hold edge.
  assign strobe_en = ~reset & ~held;
  assign IRWrite   = irwrite_raw & strobe_en;
  assign NextPC    = nextpc_raw  & strobe_en;
  assign RegW      = regw_raw    & strobe_en;
  assign MemW      = memw_raw    & strobe_en;
  assign Branch    = branch_raw  & strobe_en;
  assign state     = state_q;

  a_strobe_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0({RegW, MemW, Branch}));

  a_aluop_exec_only: assert property (@(posedge clk) disable iff (reset)
    ALUOp |-> (state_q == S_EXECUTER || state_q == S_EXECUTEI));

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the ARM-subset processor. Sits in the control unit directly upstream of `decode_alu`: it sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives the 1-bit `ALUOp` that `decode_alu` consumes together with `cmd` and `L`. All datapath mux selects and the raw write strobes originate here. Conditional gating of `RegW`, `MemW` and `Branch` is applied downstream.

## Interface
- No parameters. State encoding is fixed; see Operation.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `Op`  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- `Funct`  in  6  instruction bits [25:20]: [5] = I (immediate), [4:1] = cmd, [0] = S/L.
- `IRWrite`  out  1  instruction register load enable.
- `NextPC`  out  1  PC update strobe for the PC+4 path.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `ALUSrcA`  out  2  ALU A select: 00 = register A, 01 = PC, others reserved.
- `ALUSrcB`  out  2  ALU B select: 00 = register B, 01 = extended immediate, 10 = constant 4.
- `ResultSrc`  out  2  result mux: 00 = ALUOut, 01 = Data register, 10 = ALU result direct.
- `ALUOp`  out  1  1 = data-processing (`decode_alu` decodes cmd), 0 = add.
- `RegW`  out  1  raw register-file write strobe.
- `MemW`  out  1  raw memory write strobe.
- `Branch`  out  1  raw branch strobe.
- `state`  out  4  current state code, for debug.

## Operation
- Moore machine. Outputs are a combinational function of `state` only.
- State codes:
  - 0 FETCH
  - 1 DECODE
  - 2 MEMADR
  - 3 MEMREAD
  - 4 MEMWB
  - 5 MEMWRITE
  - 6 EXECUTER
  - 7 EXECUTEI
  - 8 ALUWB
  - 9 BRANCH
  - 10–15 illegal.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=00 & Funct[5]=0 -> EXECUTER.
  - DECODE: Op=00 & Funct[5]=1 -> EXECUTEI.
  - DECODE: Op=01 -> MEMADR.
  - DECODE: Op=10 -> BRANCH.
  - DECODE: Op=11 -> FETCH (undefined instruction treated as NOP).
  - MEMADR: Funct[0]=1 -> MEMREAD; Funct[0]=0 -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER -> ALUWB; EXECUTEI -> ALUWB; ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - Illegal codes -> FETCH on the next edge.
- Outputs per state. Anything not listed is 0; selects not listed are 00.
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
  - Illegal codes: all outputs 0.
- `Op` and `Funct` are sampled only in DECODE and MEMADR. They are ignored in every other state.
- NoWrite (CMP/CMN/TST) suppression is not handled here. ALUWB always asserts raw `RegW`.

## Timing
- `reset` asserted: `state` goes to 0 (FETCH) immediately, without waiting for `clk`.
- While `reset`=1, `IRWrite`, `NextPC`, `RegW`, `MemW` and `Branch` are forced to 0. Mux selects show FETCH values.
- Reset deassertion: the first rising edge after deassertion is FETCH with strobes enabled. No state advance occurs on that edge.
- Reset mid-instruction in any state aborts the instruction. No further strobes are issued; the machine restarts at FETCH.
- One state transition per rising edge.
- Cycles per instruction:
  - branch: 3
  - data-processing: 4
  - STR: 4
  - LDR: 5
  - undefined: 2
- `ALUOp` is high for exactly one cycle per data-processing instruction (EXECUTER or EXECUTEI). It is 0 in every other state.
- Strobes are exactly one cycle wide. No two of `RegW`, `MemW`, `Branch` are ever high in the same cycle.

## Test plan
- Reset: assert `reset` mid-MEMREAD -> `state`=0 and all strobes 0 within the same cycle. After release -> first cycle has IRWrite=1, NextPC=1.
- ADD register form (Op=00, Funct=6'b001000):
  - `state` sequence 0, 1, 6, 8, 0.
  - ALUOp=1 only in state 6.
  - RegW=1 only in state 8.
- ORR immediate (Op=00, Funct=6'b111000) -> sequence 0, 1, 7, 8, 0 with ALUSrcB=01 in state 7.
- LDR (Op=01, Funct[0]=1) -> sequence 0, 1, 2, 3, 4, 0:
  - AdrSrc=1 in state 3.
  - ResultSrc=01 and RegW=1 in state 4.
- STR (Op=01, Funct[0]=0) -> sequence 0, 1, 2, 5, 0 with MemW=1 only in state 5. Toggling Funct in state 5 has no effect.
- Branch (Op=10) -> sequence 0, 1, 9, 0 with Branch=1 in state 9.
- Undefined opcode (Op=11) -> sequence 0, 1, 0 with no strobes.
- Force an illegal state of 12 -> all outputs 0, and the next state is 0.
